// File: rtl/scan_select_sequencer.sv
// Steps the a2..a0 decoder select lines through all eight addresses, holding
// each for DWELL cycles, either up or down, in single-frame or continuous mode.
module scan_select_sequencer #(
   parameter int DWELL   = 4,
   parameter int DWELL_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic stop,
   input  logic hold,
   input  logic continuous,
   input  logic dir,
   output logic a2,
   output logic a1,
   output logic a0,
   output logic sel_valid,
   output logic busy,
   output logic frame_done
);

   // state | meaning
   // IDLE  | waiting for start, select lines parked at 000
   // SCAN  | stepping through addresses, one every DWELL cycles
   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [DWELL_W-1:0] LAST_CNT = DWELL_W'(DWELL - 1);

   state_t             state;
   logic [DWELL_W-1:0] cnt;
   logic [2:0]         addr;
   logic               dir_l;
   logic               cont_l;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         addr       <= 3'd0;
         dir_l      <= 1'b0;
         cont_l     <= 1'b0;
         sel_valid  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               frame_done <= 1'b0;
               if (start && !stop) begin
                  state     <= SCAN;
                  addr      <= dir ? 3'd7 : 3'd0;
                  dir_l     <= dir;
                  cont_l    <= continuous;
                  cnt       <= '0;
                  sel_valid <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            SCAN: begin
               if (stop) begin
                  state      <= IDLE;
                  addr       <= 3'd0;
                  cnt        <= '0;
                  sel_valid  <= 1'b0;
                  busy       <= 1'b0;
                  frame_done <= 1'b0;
               end else if (hold) begin
                  frame_done <= 1'b0;
               end else if (cnt != LAST_CNT) begin
                  cnt        <= cnt + 1'b1;
                  frame_done <= 1'b0;
               end else begin
                  cnt <= '0;
                  // stepping off the last address closes the frame
                  if (addr == (dir_l ? 3'd0 : 3'd7)) begin
                     frame_done <= 1'b1;
                     if (cont_l) begin
                        addr <= dir_l ? 3'd7 : 3'd0;
                     end else begin
                        state     <= IDLE;
                        addr      <= 3'd0;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                     end
                  end else begin
                     frame_done <= 1'b0;
                     addr       <= dir_l ? (addr - 3'd1) : (addr + 3'd1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign a2 = addr[2];
   assign a1 = addr[1];
   assign a0 = addr[0];

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Drives two sequencers (DWELL=4 and DWELL=1) with directed and random stimulus
// and compares them cycle by cycle against a frame-position reference model.
module tb_scan_select_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, stop = 1'b0, hold = 1'b0, continuous = 1'b0, dir = 1'b0;

   logic a2_4, a1_4, a0_4, sv_4, busy_4, fd_4;
   logic a2_1, a1_1, a0_1, sv_1, busy_1, fd_1;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   scan_select_sequencer #(.DWELL(4), .DWELL_W(8)) u_d4 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
      .continuous(continuous), .dir(dir),
      .a2(a2_4), .a1(a1_4), .a0(a0_4),
      .sel_valid(sv_4), .busy(busy_4), .frame_done(fd_4)
   );

   scan_select_sequencer #(.DWELL(1), .DWELL_W(4)) u_d1 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
      .continuous(continuous), .dir(dir),
      .a2(a2_1), .a1(a1_1), .a0(a0_1),
      .sel_valid(sv_1), .busy(busy_1), .frame_done(fd_1)
   );

   // reference model: a frame is just a position p in 0..8*DWELL-1
   int dwell [2] = '{4, 1};
   bit m_act  [2];
   int m_p    [2];
   bit m_dir  [2];
   bit m_cont [2];
   bit m_done [2];

   task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s at %0t: got addr/valid/busy/done=%b required %b", tag, $time, got, exp);
      end
   endtask

   function automatic logic [5:0] model_out(input int i);
      int idx;
      idx = m_p[i] / dwell[i];
      if (!m_act[i]) return {3'd0, 2'b00, m_done[i]};
      return {(m_dir[i] ? 3'(7 - idx) : 3'(idx)), 2'b11, m_done[i]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 0; m_p[i] = 0; m_dir[i] = 0; m_cont[i] = 0; m_done[i] = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (!m_act[i]) begin
            m_done[i] = 0;
            if (start && !stop) begin
               m_act[i] = 1; m_p[i] = 0; m_dir[i] = dir; m_cont[i] = continuous;
            end
         end else if (stop) begin
            m_act[i] = 0; m_p[i] = 0; m_done[i] = 0;
         end else if (hold) begin
            m_done[i] = 0;
         end else begin
            m_p[i]++;
            m_done[i] = 0;
            if (m_p[i] == 8 * dwell[i]) begin
               m_done[i] = 1;
               m_p[i] = 0;
               if (!m_cont[i]) m_act[i] = 0;
            end
         end
      end
   endtask

   task automatic compare(input string phase);
      chk({phase, "/d4"}, {a2_4, a1_4, a0_4, sv_4, busy_4, fd_4}, model_out(0));
      chk({phase, "/d1"}, {a2_1, a1_1, a0_1, sv_1, busy_1, fd_1}, model_out(1));
   endtask

   task automatic cyc(input string phase, input logic s, input logic st, input logic h,
                      input logic c, input logic d);
      start = s; stop = st; hold = h; continuous = c; dir = d;
      @(posedge clk);
      model_step();
      #1 compare(phase);
   endtask

   task automatic idle_cycles(input string phase, input int n);
      for (int k = 0; k < n; k++) cyc(phase, 0, 0, 0, 0, 0);
   endtask

   // reset lands mid-cycle; outputs must clear before any clock edge
   task automatic async_reset(input string phase);
      #3 rst = 1'b1;
      #1;
      chk({phase, "/rst_d4"}, {a2_4, a1_4, a0_4, sv_4, busy_4, fd_4}, 6'b0);
      chk({phase, "/rst_d1"}, {a2_1, a1_1, a0_1, sv_1, busy_1, fd_1}, 6'b0);
      model_reset();
      #3 rst = 1'b0;
   endtask

   initial begin
      model_reset();
      #2 compare("por");
      #1 rst = 1'b0;

      idle_cycles("quiet", 20);
      async_reset("idle");
      idle_cycles("quiet2", 3);

      cyc("up_single", 1, 0, 0, 0, 0);
      idle_cycles("up_single", 40);

      cyc("cont_down", 1, 0, 0, 1, 1);
      for (int k = 0; k < 30; k++) cyc("cont_down", 0, 0, 0, 0, 0);
      cyc("cont_down_stop", 0, 1, 0, 0, 0);
      idle_cycles("cont_down_stop", 3);

      cyc("hold", 1, 0, 0, 0, 0);
      idle_cycles("hold", 5);
      for (int k = 0; k < 5; k++) cyc("hold", 0, 0, 1, 0, 0);
      idle_cycles("hold", 40);

      // hold across the final dwell cycle
      cyc("hold_last", 1, 0, 0, 0, 0);
      idle_cycles("hold_last", 31);
      for (int k = 0; k < 3; k++) cyc("hold_last", 0, 0, 1, 0, 0);
      idle_cycles("hold_last", 5);

      cyc("stop", 1, 0, 0, 0, 0);
      idle_cycles("stop", 9);
      cyc("stop", 0, 1, 0, 0, 0);
      cyc("start_stop", 1, 1, 0, 0, 0);
      idle_cycles("start_stop", 3);

      // ignored inputs mid-scan: start, dir, continuous changes
      cyc("ignore", 1, 0, 0, 0, 0);
      for (int k = 0; k < 40; k++) cyc("ignore", 1, 0, 0, 1, 1);
      idle_cycles("ignore", 2);

      cyc("rst_scan", 1, 0, 0, 0, 0);
      idle_cycles("rst_scan", 21);
      async_reset("scan");
      cyc("restart", 1, 0, 0, 0, 0);
      idle_cycles("restart", 10);

      for (int k = 0; k < 3000; k++) begin
         logic s, st, h, c, d;
         s  = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 59) == 0);
         h  = ($urandom_range(0, 5) == 0);
         c  = $urandom_range(0, 1);
         d  = $urandom_range(0, 1);
         if ($urandom_range(0, 499) == 0) async_reset("rand");
         cyc("rand", s, st, h, c, d);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
